// File: rtl/fpumul_wbq_if.sv
`default_nettype none
// ============================================================================
// Module   : fpumul_wbq_if
// Brief    : Issue, result, writeback and status signals of the FP multiply
//            writeback queue.
// Revision : 1.0 - initial release
// ============================================================================
interface fpumul_wbq_if #(
    parameter int TAG_W = 9
);
    logic             issue_en;
    logic             iss_ok;
    logic             in_en;
    logic [67:0]      in_res;
    logic [15:0]      in_res_hi;
    logic [10:0]      in_raise;
    logic [TAG_W-1:0] in_tag;
    logic             wb_valid;
    logic             wb_ready;
    logic [67:0]      wb_res;
    logic [15:0]      wb_res_hi;
    logic [10:0]      wb_raise;
    logic [TAG_W-1:0] wb_tag;
    logic             flush;
    logic             clr_sticky;
    logic [10:0]      sticky;
    logic             ovf_err;

    modport master (
        output issue_en, in_en, in_res, in_res_hi, in_raise, in_tag,
               wb_ready, flush, clr_sticky,
        input  iss_ok, wb_valid, wb_res, wb_res_hi, wb_raise, wb_tag,
               sticky, ovf_err
    );

    modport slave (
        input  issue_en, in_en, in_res, in_res_hi, in_raise, in_tag,
               wb_ready, flush, clr_sticky,
        output iss_ok, wb_valid, wb_res, wb_res_hi, wb_raise, wb_tag,
               sticky, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/fpumul_wbq.sv
`default_nettype none
// ============================================================================
// Module   : fpumul_wbq
// Brief    : Credit-managed writeback queue behind the FP multiplier with
//            flush drop-tracking and sticky exception accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module fpumul_wbq #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 9
) (
    input  wire logic   clk,
    input  wire logic   rst,
    fpumul_wbq_if.slave wbq
);
    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [67:0]      r_res_mem   [DEPTH];
    logic [15:0]      r_hi_mem    [DEPTH];
    logic [10:0]      r_raise_mem [DEPTH];
    logic [TAG_W-1:0] r_tag_mem   [DEPTH];

    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_occ;
    logic [c_CNT_W-1:0] r_rsv_cnt;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [10:0]        r_sticky;
    logic               r_ovf_err;

    logic               w_valid;
    logic               w_dropping;
    logic               w_full;
    logic               w_pop;
    logic               w_ovf;
    logic               w_push;
    logic               w_drop_arr;
    logic [c_CNT_W:0]   w_rsv_sum;
    logic [c_CNT_W-1:0] w_rsv_next;
    logic [c_CNT_W-1:0] w_flush_cnt;
    logic [10:0]        w_sticky_next;

    assign w_valid    = (r_occ != '0);
    assign w_dropping = (r_drop_cnt != '0);
    assign w_full     = (r_occ == c_DEPTH_CNT);
    assign w_pop      = w_valid & wbq.wb_ready & ~wbq.flush;
    assign w_ovf      = wbq.in_en & ~w_dropping & w_full & ~w_pop;
    assign w_push     = wbq.in_en & ~w_dropping & ~wbq.flush & ~w_ovf;
    assign w_drop_arr = wbq.in_en & w_dropping & ~wbq.flush;

    // Credits still owed after a flush are exactly the in-flight results,
    // excluding the one arriving (and discarded) in the flush cycle itself.
    assign w_flush_cnt = r_rsv_cnt - r_occ - c_CNT_W'(wbq.in_en);

    always_comb begin
        w_rsv_sum  = {1'b0, r_rsv_cnt}
                   + (c_CNT_W+1)'(wbq.issue_en)
                   - (c_CNT_W+1)'(w_pop)
                   - (c_CNT_W+1)'(w_drop_arr);
        w_rsv_next = w_rsv_sum[c_CNT_W-1:0];
        if (w_rsv_sum > {1'b0, c_DEPTH_CNT}) begin
            w_rsv_next = c_DEPTH_CNT;
        end
    end

    assign w_sticky_next = (wbq.clr_sticky ? 11'h000 : r_sticky)
                         | (w_pop ? r_raise_mem[r_rd_ptr] : 11'h000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_occ      <= '0;
            r_rsv_cnt  <= '0;
            r_drop_cnt <= '0;
            r_sticky   <= '0;
            r_ovf_err  <= 1'b0;
        end else begin
            r_sticky <= w_sticky_next;
            if (w_ovf) begin
                r_ovf_err <= 1'b1;
            end
            if (wbq.flush) begin
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_occ      <= '0;
                r_rsv_cnt  <= w_flush_cnt;
                r_drop_cnt <= w_flush_cnt;
            end else begin
                r_rsv_cnt <= w_rsv_next;
                if (w_drop_arr) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_occ <= r_occ + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
        end
    end

    // Payload storage carries no reset; wb_* are only meaningful with wb_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_res_mem[r_wr_ptr]   <= wbq.in_res;
            r_hi_mem[r_wr_ptr]    <= wbq.in_res_hi;
            r_raise_mem[r_wr_ptr] <= wbq.in_raise;
            r_tag_mem[r_wr_ptr]   <= wbq.in_tag;
        end
    end

    assign wbq.wb_valid  = w_valid;
    assign wbq.wb_res    = r_res_mem[r_rd_ptr];
    assign wbq.wb_res_hi = r_hi_mem[r_rd_ptr];
    assign wbq.wb_raise  = r_raise_mem[r_rd_ptr];
    assign wbq.wb_tag    = r_tag_mem[r_rd_ptr];
    assign wbq.iss_ok    = (r_rsv_cnt < c_DEPTH_CNT);
    assign wbq.sticky    = r_sticky;
    assign wbq.ovf_err   = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_fpumul_wbq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpumul_wbq
// Brief    : Directed scoreboard bench for the FP multiply writeback queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpumul_wbq;
    localparam int DEPTH = 4;
    localparam int TAG_W = 9;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [67:0]      res;
        logic [15:0]      hi;
        logic [10:0]      raise;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t sb [$];

    fpumul_wbq_if #(.TAG_W(TAG_W)) bus ();

    fpumul_wbq #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .wbq (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [67:0] mk_res(int t);
        return {4'hA, 32'hC0DE_0000, 32'(t)};
    endfunction

    function automatic logic [15:0] mk_hi(int t);
        return 16'(t * 3) ^ 16'h8000;
    endfunction

    task automatic check_val(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(int n);
        for (int i = 0; i < n; i++) begin
            bus.issue_en = 1'b1;
            step();
        end
        bus.issue_en = 1'b0;
    endtask

    task automatic drive_result(int t, logic [10:0] raise, bit expect_out);
        exp_t e;
        bus.in_en     = 1'b1;
        bus.in_tag    = TAG_W'(t);
        bus.in_res    = mk_res(t);
        bus.in_res_hi = mk_hi(t);
        bus.in_raise  = raise;
        if (expect_out) begin
            e.tag   = TAG_W'(t);
            e.res   = mk_res(t);
            e.hi    = mk_hi(t);
            e.raise = raise;
            sb.push_back(e);
        end
    endtask

    task automatic send_result(int t, logic [10:0] raise, bit expect_out);
        drive_result(t, raise, expect_out);
        step();
        bus.in_en = 1'b0;
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check_val({name, "_drain_left"}, sb.size(), 0);
    endtask

    // Monitor: every accepted writeback must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (rst && bus.wb_valid && bus.wb_ready && !bus.flush) begin
            checks++;
            a.tag   = bus.wb_tag;
            a.res   = bus.wb_res;
            a.hi    = bus.wb_res_hi;
            a.raise = bus.wb_raise;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: got tag %0d with nothing expected", a.tag);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL wb_entry: got tag %0d res %0h hi %0h raise %0h expected tag %0d res %0h hi %0h raise %0h",
                             a.tag, a.res, a.hi, a.raise, e.tag, e.res, e.hi, e.raise);
                end
            end
        end
    end

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b0;
        bus.issue_en     = 1'b0;
        bus.in_en        = 1'b0;
        bus.in_res       = '0;
        bus.in_res_hi    = '0;
        bus.in_raise     = '0;
        bus.in_tag       = '0;
        bus.wb_ready     = 1'b0;
        bus.flush        = 1'b0;
        bus.clr_sticky   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_wb_valid", int'(bus.wb_valid), 0);
        check_val("rst_iss_ok",   int'(bus.iss_ok),   1);
        check_val("rst_sticky",   int'(bus.sticky),   0);
        check_val("rst_ovf_err",  int'(bus.ovf_err),  0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Basic flow: three results straight through.
        bus.wb_ready = 1'b1;
        issue(3);
        check_val("t1_iss_ok", int'(bus.iss_ok), 1);
        send_result(5, 11'h000, 1'b1);
        send_result(6, 11'h000, 1'b1);
        send_result(7, 11'h000, 1'b1);
        wait_drain("t1");
        step();
        check_val("t1_rsv_cnt", int'(dut.r_rsv_cnt), 0);
        check_val("t1_iss_ok_end", int'(bus.iss_ok), 1);

        // Fill, single pop frees a credit, then wrap-around streaming.
        bus.wb_ready = 1'b0;
        issue(4);
        for (int i = 0; i < 4; i++) send_result(10 + i, 11'h000, 1'b1);
        check_val("t2_iss_ok_full", int'(bus.iss_ok), 0);
        check_val("t2_wb_valid", int'(bus.wb_valid), 1);
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
        check_val("t2_iss_ok_after_pop", int'(bus.iss_ok), 1);
        check_val("t2_sb_after_pop", sb.size(), 3);
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.issue_en = 1'b1;
            drive_result(14 + i, 11'h000, 1'b1);
            step();
        end
        bus.issue_en = 1'b0;
        bus.in_en    = 1'b0;
        wait_drain("t2");
        step();
        check_val("t2_rsv_cnt", int'(dut.r_rsv_cnt), 0);

        // Flush with results in flight.
        bus.wb_ready = 1'b0;
        issue(4);
        send_result(20, 11'h000, 1'b1);
        send_result(21, 11'h000, 1'b1);
        bus.flush = 1'b1;
        send_result(22, 11'h000, 1'b0);
        bus.flush = 1'b0;
        sb.delete();
        check_val("t3_wb_valid_flush", int'(bus.wb_valid), 0);
        check_val("t3_rsv_after_flush", int'(dut.r_rsv_cnt), 1);
        bus.wb_ready = 1'b1;
        send_result(23, 11'h000, 1'b0);
        step();
        check_val("t3_wb_valid_drop", int'(bus.wb_valid), 0);
        check_val("t3_rsv_cnt", int'(dut.r_rsv_cnt), 0);
        check_val("t3_iss_ok", int'(bus.iss_ok), 1);

        // Sticky accumulation and clear-with-pop.
        bus.wb_ready = 1'b0;
        check_val("t4_sticky_init", int'(bus.sticky), 0);
        issue(3);
        send_result(30, 11'h001, 1'b1);
        send_result(31, 11'h010, 1'b1);
        send_result(32, 11'h100, 1'b1);
        bus.wb_ready = 1'b1;
        step();
        step();
        check_val("t4_sticky_before_clr", int'(bus.sticky), 'h011);
        bus.clr_sticky = 1'b1;
        step();
        bus.clr_sticky = 1'b0;
        bus.wb_ready   = 1'b0;
        check_val("t4_sticky_after_clr", int'(bus.sticky), 'h100);
        check_val("t4_sb_empty", sb.size(), 0);

        // Overflow: illegal arrival into a full queue.
        issue(4);
        for (int i = 0; i < 4; i++) send_result(40 + i, 11'h000, 1'b1);
        check_val("t5_ovf_before", int'(bus.ovf_err), 0);
        send_result(99, 11'h7FF, 1'b0);
        check_val("t5_ovf_after", int'(bus.ovf_err), 1);
        check_val("t5_wb_valid", int'(bus.wb_valid), 1);
        check_val("t5_wb_tag_head", int'(bus.wb_tag), 40);
        bus.wb_ready = 1'b1;
        wait_drain("t5");
        step();
        check_val("t5_empty", int'(bus.wb_valid), 0);
        check_val("t5_sticky_untouched", int'(bus.sticky), 'h100);
        bus.wb_ready = 1'b0;

        // Asynchronous reset with entries queued.
        issue(3);
        for (int i = 0; i < 3; i++) send_result(50 + i, 11'h000, 1'b1);
        check_val("t6_wb_valid_pre", int'(bus.wb_valid), 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("t6_wb_valid", int'(bus.wb_valid), 0);
        check_val("t6_iss_ok",   int'(bus.iss_ok),   1);
        check_val("t6_sticky",   int'(bus.sticky),   0);
        check_val("t6_ovf_err",  int'(bus.ovf_err),  0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        check_val("t6_wb_valid_post", int'(bus.wb_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fpumul_wbq.md
# fpumul_wbq

Writeback queue directly downstream of the FP multiply/round stage. Captures each valid multiplier result (68-bit result word, 16-bit high exponent word, 11-bit exception vector) with its destination tag. Holds results until the shared FP writeback port grants them and OR-accumulates the exception flags of written-back results into a sticky vector for the fpcsr. Issue-side credit accounting covers multiplier results still in flight, so the fixed-latency multiplier never overruns the queue. Flush discards both queued and in-flight results.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, 2..16.
- TAG_W, 9: destination tag width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- issue_en  in  1  a multiply is issued this cycle and consumes one credit.
- iss_ok  out  1  credit available: rsv_cnt < DEPTH.
- in_en  in  1  multiplier result valid this cycle.
- in_res  in  68  result word.
- in_res_hi  in  16  high exponent word.
- in_raise  in  11  exception vector.
- in_tag  in  TAG_W  destination tag.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  writeback port accepts the head.
- wb_res, wb_res_hi, wb_raise, wb_tag  out  68/16/11/TAG_W  head entry fields.
- flush  in  1  discard all queued and in-flight results.
- clr_sticky  in  1  clear the sticky flags.
- sticky  out  11  OR of wb_raise over all pops since the last clear.
- ovf_err  out  1  sticky error: in_en accepted while the queue was full.

## Operation
- Storage: circular buffer of DEPTH entries with rd_ptr and wr_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH. occ is log2(DEPTH)+1 bits.
- Push: in_en & ~dropping & ~flush writes the entry at wr_ptr, then wr_ptr++ and occ++.
- Pop: wb_valid & wb_ready & ~flush advances rd_ptr and decrements occ. wb_valid = (occ != 0).
- A simultaneous push and pop leaves occ unchanged. Pushing into an empty queue while popping is impossible because wb_valid=0.
- Credit counter rsv_cnt (log2(DEPTH)+1 bits) counts queued entries plus in-flight results.
  - +1 on issue_en & ~flush.
  - −1 on each pop, and −1 on each dropped arrival.
  - Net change per cycle is the sum of these terms.
  - issue_en while iss_ok=0 is a protocol violation; rsv_cnt saturates at DEPTH.
- Flush (single cycle):
  - occ, rd_ptr and wr_ptr all go to 0.
  - drop_cnt is set to rsv_cnt − occ − (in_en ? 1 : 0).
  - rsv_cnt is set to that same drop_cnt value.
  - issue_en, pop and push in the flush cycle are ignored; the in_en result arriving in that cycle is discarded.
- Drop mode: dropping = (drop_cnt != 0). While dropping, in_en decrements drop_cnt and rsv_cnt and does not write the queue.
- Sticky flags: next value is (clr_sticky ? 0 : sticky) | (pop ? wb_raise : 0), so a pop in a clear cycle is kept. Flush does not affect sticky.
- Overflow: in_en & ~dropping & (occ==DEPTH) & ~pop sets ovf_err and discards the data. ovf_err clears only on reset.

## Timing
- Reset values (rst=0, asynchronous): occ=0, rd_ptr=wr_ptr=0, rsv_cnt=0, drop_cnt=0, sticky=0, ovf_err=0. Therefore wb_valid=0 and iss_ok=1. Entry storage is not reset; wb_* data is don't-care while wb_valid=0.
- Reset deasserted mid-operation: all state comes up at reset values. Results arriving afterwards without a matching issue_en are protocol violations.
- Push latency: in_en at posedge N makes the entry visible on wb_* after posedge N (registered, no bypass).
- wb_* come directly from storage at rd_ptr. wb_valid depends only on registered state, never combinationally on wb_ready.
- iss_ok is a combinational decode of registered rsv_cnt. A credit freed by a pop in cycle N is usable in cycle N+1.
- Back-to-back pops: one per cycle at full throughput when wb_ready is held high.

## Test plan
- Reset, issue 3, return 3 results with tags 5, 6, 7 and wb_ready=1 → wb_tag 5, 6, 7 on consecutive cycles; rsv_cnt returns to 0; iss_ok stays 1.
- wb_ready=0, issue and return 4 results → occ=4, iss_ok=0. Raise wb_ready for 1 cycle → one pop, iss_ok=1 the next cycle; wrap-around order is preserved over 10 entries.
- Issue 4, return 2, flush in the same cycle as the 3rd in_en → queue empty; the 4th result is dropped and does not appear; rsv_cnt reaches 0 after it arrives.
- Pop entries with raise 11'h001 and 11'h010, then assert clr_sticky in the same cycle as popping 11'h100 → sticky=11'h011 before the clear, 11'h100 after it.
- Queue full with wb_ready=0, inject an illegal in_en → ovf_err=1, occ stays 4, queue contents unchanged.
- Assert rst low with occ=3 → wb_valid=0, iss_ok=1, sticky=0 immediately, without a clock edge.
